// File: rtl/tt_sweep7.sv
// tt_sweep7 -- sequential truth-table extractor for 7-input function networks.
//
// Drives every minterm 0..127 onto a combinational function-under-test (FUT),
// samples its single output once per minterm and assembles the 128-bit truth
// table, tt[k] = FUT output at minterm k (so tt printed MSB-first is the hex
// signature, bit 127 first).
//
// Parameters:
//   SETTLE   extra cycles each minterm is held before sampling (0..15)
//
// Configuration macro:
//   TT_WEIGHT_EN  when defined, builds the onset counter behind `weight`;
//                 otherwise `weight` is tied to zero.
//
// Ports:
//   clk       in   1    rising-edge clock
//   rst_n     in   1    synchronous active-low reset
//   start     in   1    request a sweep; accepted only when idle
//   fut_out   in   1    FUT output (combinational from x)
//   x         out  7    minterm driven to the FUT
//   busy      out  1    sweep in progress
//   done      out  1    one-cycle pulse when the sweep completes
//   tt_valid  out  1    tt holds a complete table
//   tt        out  128  truth table (partial while busy)
//   weight    out  8    onset size 0..128

module tt_sweep7 #(
    parameter int unsigned SETTLE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         fut_out,
    output logic [6:0]   x,
    output logic         busy,
    output logic         done,
    output logic         tt_valid,
    output logic [127:0] tt,
    output logic [7:0]   weight
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state;
    logic [6:0] idx;
    logic [3:0] wait_cnt;
    logic       sample;

    // The current minterm has been held long enough; take its sample this edge.
    assign sample = (state == RUN) && (wait_cnt == SETTLE_C);

    // idx is cleared on accept and wraps to 0 after minterm 127, so it is
    // always 0 in IDLE and can drive x directly without a mux.
    assign x    = idx;
    assign busy = (state == RUN);

    // NOTE: all state here is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, regardless of order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            wait_cnt <= '0;
            done     <= 1'b0;
            tt_valid <= 1'b0;
            tt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        idx      <= '0;
                        wait_cnt <= '0;
                        tt_valid <= 1'b0;
                        tt       <= '0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        tt[idx]  <= fut_out;
                        wait_cnt <= '0;
                        idx      <= idx + 7'd1;
                        // Last minterm: leave RUN on the same edge as its sample.
                        if (idx == 7'd127) begin
                            state    <= IDLE;
                            done     <= 1'b1;
                            tt_valid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TT_WEIGHT_EN
    logic [7:0] weight_q;

    // Onset counter; at most 128 samples, so 8 bits never overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight_q <= '0;
        end else if (state == IDLE && start) begin
            weight_q <= '0;
        end else if (sample) begin
            weight_q <= weight_q + {7'd0, fut_out};
        end
    end

    assign weight = weight_q;
`else
    assign weight = 8'd0;
`endif

endmodule

// File: tb/tb_tt_sweep7.sv
// Self-checking bench for tt_sweep7. Two instances run side by side:
// index 0 with SETTLE=0 and index 1 with SETTLE=1. A cycle model derived from
// the sweep timing rules predicts every output each cycle; directed sweeps
// add literal expectations for the named tables, weights and latencies.

module tb_tt_sweep7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        start_v;
    logic [1:0]        fut_v;
    logic [1:0][6:0]   x_v;
    logic [1:0]        busy_v;
    logic [1:0]        done_v;
    logic [1:0]        valid_v;
    logic [1:0][127:0] tt_v;
    logic [1:0][7:0]   w_v;
    int                fsel_v [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    // FUT library: 0 const 0, 1 x0, 2 x6, 3 majority(x0,x1,x2), 4 AND of all.
    function automatic logic fut_fn(input int sel, input logic [6:0] k);
        case (sel)
            1:       return k[0];
            2:       return k[6];
            3:       return (k[0] & k[1]) | (k[0] & k[2]) | (k[1] & k[2]);
            4:       return &k;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [127:0] full_table(input int sel);
        logic [127:0] t;
        t = '0;
        for (int k = 0; k < 128; k++) t[k] = fut_fn(sel, 7'(k));
        return t;
    endfunction

    function automatic int exp_w(input int v);
`ifdef TT_WEIGHT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    assign fut_v[0] = fut_fn(fsel_v[0], x_v[0]);
    assign fut_v[1] = fut_fn(fsel_v[1], x_v[1]);

    tt_sweep7 #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .fut_out(fut_v[0]),
        .x(x_v[0]), .busy(busy_v[0]), .done(done_v[0]), .tt_valid(valid_v[0]),
        .tt(tt_v[0]), .weight(w_v[0])
    );

    tt_sweep7 #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .fut_out(fut_v[1]),
        .x(x_v[1]), .busy(busy_v[1]), .done(done_v[1]), .tt_valid(valid_v[1]),
        .tt(tt_v[1]), .weight(w_v[1])
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // n_m: edges since the accepting edge (-1 = no table since reset),
    // saturating at L+1 where L = 128*(SETTLE+1) is the sweep length.
    int           n_m   [2];
    logic [127:0] tab_m [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                n_m[i]   <= -1;
                tab_m[i] <= '0;
            end else if ((n_m[i] < 0 || n_m[i] >= 128 * (i + 1)) && start_v[i]) begin
                n_m[i]   <= 0;
                tab_m[i] <= full_table(fsel_v[i]);
            end else if (n_m[i] >= 0 && n_m[i] <= 128 * (i + 1)) begin
                n_m[i]   <= n_m[i] + 1;
            end
        end
    end

    task automatic compare(input int i);
        int           n, len, m;
        logic [6:0]   e_x;
        logic         e_busy, e_done, e_valid;
        logic [127:0] e_tt;
        n   = n_m[i];
        len = 128 * (i + 1);
        e_x = '0; e_busy = 0; e_done = 0; e_valid = 0; e_tt = '0;
        if (n >= 0 && n < len) begin
            m      = n / (i + 1);         // minterms already sampled
            e_x    = 7'(m);
            e_busy = 1'b1;
            e_tt   = tab_m[i] & ((128'd1 << m) - 128'd1);
        end else if (n >= len) begin
            e_done  = (n == len);
            e_valid = 1'b1;
            e_tt    = tab_m[i];
        end
        check($sformatf("u%0d x", i),        128'(x_v[i]),    128'(e_x));
        check($sformatf("u%0d busy", i),     128'(busy_v[i]), 128'(e_busy));
        check($sformatf("u%0d done", i),     128'(done_v[i]), 128'(e_done));
        check($sformatf("u%0d tt_valid", i), 128'(valid_v[i]), 128'(e_valid));
        check($sformatf("u%0d tt", i),       tt_v[i],          e_tt);
        check($sformatf("u%0d weight", i),   128'(w_v[i]),     128'(exp_w($countones(e_tt))));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            compare(0);
            compare(1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_sweep(input int i, input int fs, input int ign,
                             output logic [127:0] tt_o, output logic [7:0] w_o);
        int cyc, bc;
        @(negedge clk);
        fsel_v[i]  = fs;
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        cyc = 0;
        bc  = busy_v[i] ? 1 : 0;
        while (!done_v[i] && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (busy_v[i]) bc++;
            start_v[i] = (cyc == ign);   // start while busy must be ignored
        end
        start_v[i] = 1'b0;
        check($sformatf("u%0d f%0d done latency", i, fs), 128'(cyc), 128'(128 * (i + 1)));
        check($sformatf("u%0d f%0d busy cycles", i, fs), 128'(bc), 128'(128 * (i + 1)));
        tt_o = tt_v[i];
        w_o  = w_v[i];
    endtask

    logic [127:0] t;
    logic [7:0]   w;

    initial begin
        rst_n     = 1'b0;
        start_v   = '0;
        fsel_v[0] = 0;
        fsel_v[1] = 0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("reset tt", tt_v[0], 128'h0);
        check("reset busy", 128'(busy_v[0]), 128'h0);
        check("reset tt_valid", 128'(valid_v[1]), 128'h0);
        rst_n = 1'b1;

        run_sweep(0, 0, -1, t, w);
        check("const0 tt", t, 128'h0);
        check("const0 weight", 128'(w), 128'(exp_w(0)));

        run_sweep(0, 1, -1, t, w);
        check("x0 tt", t, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
        check("x0 weight", 128'(w), 128'(exp_w(64)));

        run_sweep(0, 2, -1, t, w);
        check("x6 tt", t, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000);
        check("x6 weight", 128'(w), 128'(exp_w(64)));

        run_sweep(1, 3, -1, t, w);
        check("maj s1 tt", t, 128'hE8E8_E8E8_E8E8_E8E8_E8E8_E8E8_E8E8_E8E8);
        check("maj s1 weight", 128'(w), 128'(exp_w(64)));

        run_sweep(0, 4, 50, t, w);
        check("and7 tt", t, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        check("and7 weight", 128'(w), 128'(exp_w(1)));
        repeat (4) @(negedge clk);
        check("and7 no second sweep", 128'(busy_v[0]), 128'h0);
        check("and7 table held", 128'(valid_v[0]), 128'h1);

        // start held high: re-accepted in the cycle after done
        @(negedge clk);
        fsel_v[0]  = 1;
        start_v[0] = 1'b1;
        for (int c = 0; c < 200 && !done_v[0]; c++) @(negedge clk);
        check("held start done seen", 128'(done_v[0]), 128'h1);
        @(negedge clk);
        check("held start restart busy", 128'(busy_v[0]), 128'h1);
        check("held start valid cleared", 128'(valid_v[0]), 128'h0);
        start_v[0] = 1'b0;

        // reset at cycle 70 of the restarted sweep
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset tt", tt_v[0], 128'h0);
        check("midreset busy", 128'(busy_v[0]), 128'h0);
        check("midreset x", 128'(x_v[0]), 128'h0);
        check("midreset tt_valid", 128'(valid_v[0]), 128'h0);
        check("midreset weight", 128'(w_v[0]), 128'h0);
        rst_n = 1'b1;

        run_sweep(0, 3, -1, t, w);
        check("post reset maj tt", t, 128'hE8E8_E8E8_E8E8_E8E8_E8E8_E8E8_E8E8_E8E8);
        check("post reset maj weight", 128'(w), 128'(exp_w(64)));

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
